// File: rtl/ps2_scancode_to_ascii_if.sv
// Scan-code in / ASCII out bundle between the PS/2 receiver, the translator and its consumer.
// The master side drives scan codes and observes characters; the translator is the slave.
interface ps2_scancode_to_ascii_if;
    logic       ps2_code_new;
    logic [7:0] ps2_code;
    logic       ascii_new;
    logic [6:0] ascii_code;
    logic       caps_lock;

    modport master (
        output ps2_code_new, ps2_code,
        input  ascii_new, ascii_code, caps_lock
    );

    modport slave (
        input  ps2_code_new, ps2_code,
        output ascii_new, ascii_code, caps_lock
    );
endinterface

// File: rtl/ps2_scancode_to_ascii.sv
// PS/2 set-2 scan code to 7-bit ASCII translator (US layout) with Shift/Ctrl/Caps Lock and Pause skip.
// Result pulse two cycles after the code_new rising edge; never stalls, one byte per edge.
module ps2_scancode_to_ascii (
    input  logic                          clk,
    input  logic                          reset,
    ps2_scancode_to_ascii_if.slave        bus
);
    logic       prev_q, vld_q;
    logic [7:0] code_q;
    logic       brk_q, brk_d, ext_q, ext_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic       caps_q, caps_d, caps_held_q, caps_held_d;
    logic [2:0] skip_q, skip_d;
    logic       new_q, new_d;
    logic [6:0] ascii_q, ascii_d;

    logic       is_letter, is_sym, shift, ctrl;
    logic [4:0] letter_idx;
    logic [6:0] sym_lo, sym_hi;

    assign shift = lshift_q | rshift_q;
    assign ctrl  = lctrl_q | rctrl_q;

    always_comb begin
        is_letter  = 1'b1;
        letter_idx = 5'd0;
        case (code_q)
            8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;   8'h21: letter_idx = 5'd2;
            8'h23: letter_idx = 5'd3;   8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
            8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;   8'h43: letter_idx = 5'd8;
            8'h3B: letter_idx = 5'd9;   8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
            8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;  8'h44: letter_idx = 5'd14;
            8'h4D: letter_idx = 5'd15;  8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
            8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;  8'h3C: letter_idx = 5'd20;
            8'h2A: letter_idx = 5'd21;  8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
            8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
    end

    // Non-letter keys: unshifted / shifted character; control keys map to themselves under shift.
    always_comb begin
        is_sym = 1'b1;
        sym_lo = 7'h00;
        sym_hi = 7'h00;
        case (code_q)
            8'h16: begin sym_lo = 7'h31; sym_hi = 7'h21; end
            8'h1E: begin sym_lo = 7'h32; sym_hi = 7'h40; end
            8'h26: begin sym_lo = 7'h33; sym_hi = 7'h23; end
            8'h25: begin sym_lo = 7'h34; sym_hi = 7'h24; end
            8'h2E: begin sym_lo = 7'h35; sym_hi = 7'h25; end
            8'h36: begin sym_lo = 7'h36; sym_hi = 7'h5E; end
            8'h3D: begin sym_lo = 7'h37; sym_hi = 7'h26; end
            8'h3E: begin sym_lo = 7'h38; sym_hi = 7'h2A; end
            8'h46: begin sym_lo = 7'h39; sym_hi = 7'h28; end
            8'h45: begin sym_lo = 7'h30; sym_hi = 7'h29; end
            8'h0E: begin sym_lo = 7'h60; sym_hi = 7'h7E; end
            8'h4E: begin sym_lo = 7'h2D; sym_hi = 7'h5F; end
            8'h55: begin sym_lo = 7'h3D; sym_hi = 7'h2B; end
            8'h54: begin sym_lo = 7'h5B; sym_hi = 7'h7B; end
            8'h5B: begin sym_lo = 7'h5D; sym_hi = 7'h7D; end
            8'h5D: begin sym_lo = 7'h5C; sym_hi = 7'h7C; end
            8'h4C: begin sym_lo = 7'h3B; sym_hi = 7'h3A; end
            8'h52: begin sym_lo = 7'h27; sym_hi = 7'h22; end
            8'h41: begin sym_lo = 7'h2C; sym_hi = 7'h3C; end
            8'h49: begin sym_lo = 7'h2E; sym_hi = 7'h3E; end
            8'h4A: begin sym_lo = 7'h2F; sym_hi = 7'h3F; end
            8'h29: begin sym_lo = 7'h20; sym_hi = 7'h20; end
            8'h5A: begin sym_lo = 7'h0D; sym_hi = 7'h0D; end
            8'h66: begin sym_lo = 7'h08; sym_hi = 7'h08; end
            8'h0D: begin sym_lo = 7'h09; sym_hi = 7'h09; end
            8'h76: begin sym_lo = 7'h1B; sym_hi = 7'h1B; end
            default: is_sym = 1'b0;
        endcase
    end

    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        skip_d      = skip_q;
        new_d       = 1'b0;
        ascii_d     = ascii_q;
        if (vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (code_q == 8'hE1) begin
                skip_d = 3'd7;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                case (code_q)
                    8'h12: lshift_d = ~brk_q;
                    8'h59: rshift_d = ~brk_q;
                    8'h14: begin
                        if (ext_q) rctrl_d = ~brk_q;
                        else       lctrl_d = ~brk_q;
                    end
                    // Caps toggles only on the first make; typematic repeats are ignored until break.
                    8'h58: begin
                        if (brk_q) begin
                            caps_held_d = 1'b0;
                        end else begin
                            if (!caps_held_q) caps_d = ~caps_q;
                            caps_held_d = 1'b1;
                        end
                    end
                    default: begin
                        if (!brk_q) begin
                            if (ext_q) begin
                                if (code_q == 8'h4A) begin
                                    new_d = 1'b1; ascii_d = 7'h2F;
                                end else if (code_q == 8'h5A) begin
                                    new_d = 1'b1; ascii_d = 7'h0D;
                                end
                            end else if (is_letter) begin
                                new_d = 1'b1;
                                if (ctrl)                ascii_d = {2'b00, letter_idx} + 7'h01;
                                else if (shift ^ caps_q) ascii_d = {2'b00, letter_idx} + 7'h41;
                                else                     ascii_d = {2'b00, letter_idx} + 7'h61;
                            end else if (is_sym) begin
                                new_d   = 1'b1;
                                ascii_d = shift ? sym_hi : sym_lo;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // prev_q resets high so a level already present at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= 1'b1;
            vld_q       <= 1'b0;
            code_q      <= 8'h00;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            skip_q      <= 3'd0;
            new_q       <= 1'b0;
            ascii_q     <= 7'h00;
        end else begin
            prev_q      <= bus.ps2_code_new;
            vld_q       <= bus.ps2_code_new & ~prev_q;
            if (bus.ps2_code_new && !prev_q) code_q <= bus.ps2_code;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            skip_q      <= skip_d;
            new_q       <= new_d;
            ascii_q     <= ascii_d;
        end
    end

    assign bus.ascii_new  = new_q;
    assign bus.ascii_code = ascii_q;
    assign bus.caps_lock  = caps_q;
endmodule
